// File: rtl/adsr_pkg.sv
// Shared types, envelope time constants and step-table helpers for the
// polyphonic ADSR envelope generator.
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  localparam int NUM_TIME_CODES = 16;

  // Attack times in microseconds; decay/release use DR_TIME_MULT times these.
  localparam logic [63:0] ATTACK_US [NUM_TIME_CODES] = '{
    64'd2000,   64'd8000,   64'd16000,  64'd24000,
    64'd38000,  64'd56000,  64'd68000,  64'd80000,
    64'd100000, 64'd250000, 64'd500000, 64'd800000,
    64'd1000000, 64'd3000000, 64'd5000000, 64'd8000000
  };
  localparam logic [63:0] DR_TIME_MULT = 64'd3;

  function automatic logic [63:0] time_step(input logic [63:0] t_us, input int acc_bits,
                                            input int clk_freq);
    return ((64'd1 << acc_bits) * 64'd1000000) / (t_us * 64'(clk_freq));
  endfunction

  function automatic logic [63:0] attack_step(input int code, input int acc_bits,
                                              input int clk_freq);
    int idx;
    idx = (code < NUM_TIME_CODES) ? code : NUM_TIME_CODES - 1;
    return time_step(ATTACK_US[idx], acc_bits, clk_freq);
  endfunction

  function automatic logic [63:0] dr_step(input int code, input int acc_bits,
                                          input int clk_freq);
    int idx;
    idx = (code < NUM_TIME_CODES) ? code : NUM_TIME_CODES - 1;
    return time_step(ATTACK_US[idx] * DR_TIME_MULT, acc_bits, clk_freq);
  endfunction

  // Bit i of the sustain level is s[i mod ctrl_width]: s replicated across the accumulator.
  function automatic logic [63:0] sustain_rep(input logic [15:0] s, input int acc_bits,
                                              input int ctrl_width);
    logic [63:0] rep;
    rep = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < acc_bits) begin
        rep[i] = s[i % ctrl_width];
      end
    end
    return rep;
  endfunction

endpackage

// File: rtl/adsr_voice_step.sv
// Combinational single-voice ADSR update: gate-driven transition first, then
// the step of the resulting state with exact saturation.
module adsr_voice_step
  import adsr_pkg::*;
#(
  parameter int ACCUMULATOR_BITS = 24,
  parameter int CTRL_WIDTH       = 4,
  parameter int SAMPLE_CLK_FREQ  = 48000,
  parameter int RETRIGGER        = 0
) (
  input  logic [2:0]                  i_state,
  input  logic [ACCUMULATOR_BITS-1:0] i_acc,
  input  logic                        i_gate_q,
  input  logic                        i_g,
  input  logic [CTRL_WIDTH-1:0]       i_a,
  input  logic [CTRL_WIDTH-1:0]       i_d,
  input  logic [CTRL_WIDTH-1:0]       i_s,
  input  logic [CTRL_WIDTH-1:0]       i_r,
  output logic [2:0]                  o_state,
  output logic [ACCUMULATOR_BITS-1:0] o_acc,
  output logic                        o_gate_q
);
  localparam int AB    = ACCUMULATOR_BITS;
  localparam int NCODE = 2 ** CTRL_WIDTH;
  localparam logic [AB-1:0] ZERO = {AB{1'b0}};
  localparam logic [AB-1:0] ONES = {AB{1'b1}};

  logic [AB-1:0] w_atk_tbl [NCODE];
  logic [AB-1:0] w_dr_tbl  [NCODE];

  for (genvar gi = 0; gi < NCODE; gi++) begin : g_tbl
    localparam logic [AB-1:0] ATK_STEP = AB'(attack_step(gi, AB, SAMPLE_CLK_FREQ));
    localparam logic [AB-1:0] DR_STEP  = AB'(dr_step(gi, AB, SAMPLE_CLK_FREQ));
    assign w_atk_tbl[gi] = ATK_STEP;
    assign w_dr_tbl[gi]  = DR_STEP;
  end

  adsr_state_e   w_st;
  logic [AB-1:0] w_base;
  logic [AB-1:0] w_sus;
  logic [AB:0]   w_sum;
  logic [AB:0]   w_dec;
  logic [AB:0]   w_rel;

  assign w_sus    = AB'(sustain_rep(16'(i_s), AB, CTRL_WIDTH));
  assign w_sum    = {1'b0, w_base} + {1'b0, w_atk_tbl[i_a]};
  assign w_dec    = {1'b0, w_base} - {1'b0, w_dr_tbl[i_d]};
  assign w_rel    = {1'b0, w_base} - {1'b0, w_dr_tbl[i_r]};
  assign o_gate_q = i_g;

  // Gate-driven transition and choice of the accumulator the step starts from
  always_comb begin
    w_st   = adsr_state_e'(i_state);
    w_base = i_acc;
    if (i_g && (!i_gate_q || i_state == ST_OFF)) begin
      w_st = ST_ATTACK;
      if (RETRIGGER != 0) begin
        w_base = ZERO;
      end else begin
        w_base = i_acc;
      end
    end else if (!i_g && (i_state == ST_ATTACK || i_state == ST_DECAY ||
                          i_state == ST_SUSTAIN)) begin
      w_st = ST_RELEASE;
    end else begin
      w_st = adsr_state_e'(i_state);
    end
  end

  // Step of the resulting state, clamping on carry/borrow or on reaching the target
  always_comb begin
    o_state = w_st;
    o_acc   = w_base;
    case (w_st)
      ST_ATTACK: begin
        if (w_sum[AB] || w_sum[AB-1:0] == ONES) begin
          o_acc   = ONES;
          o_state = ST_DECAY;
        end else begin
          o_acc   = w_sum[AB-1:0];
          o_state = ST_ATTACK;
        end
      end
      ST_DECAY: begin
        if (w_dec[AB] || w_dec[AB-1:0] <= w_sus) begin
          o_acc   = w_sus;
          o_state = ST_SUSTAIN;
        end else begin
          o_acc   = w_dec[AB-1:0];
          o_state = ST_DECAY;
        end
      end
      ST_SUSTAIN: begin
        o_acc   = w_sus;
        o_state = ST_SUSTAIN;
      end
      ST_RELEASE: begin
        if (w_rel[AB] || w_rel[AB-1:0] == ZERO) begin
          o_acc   = ZERO;
          o_state = ST_OFF;
        end else begin
          o_acc   = w_rel[AB-1:0];
          o_state = ST_RELEASE;
        end
      end
      default: begin
        o_acc   = ZERO;
        o_state = ST_OFF;
      end
    endcase
  end

endmodule

// File: rtl/adsr_poly.sv
// Time-multiplexed polyphonic ADSR: each accepted sample strobe sweeps all
// voices through one shared update datapath and streams the new levels out.
module adsr_poly
  import adsr_pkg::*;
#(
  parameter int VOICES           = 8,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int CTRL_WIDTH       = 4,
  parameter int OUT_BITS         = 16,
  parameter int SAMPLE_CLK_FREQ  = 48000,
  parameter int RETRIGGER        = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          low_strobe,
  input  logic [VOICES-1:0]                             gate,
  input  logic [VOICES*CTRL_WIDTH-1:0]                  a,
  input  logic [VOICES*CTRL_WIDTH-1:0]                  d,
  input  logic [VOICES*CTRL_WIDTH-1:0]                  s,
  input  logic [VOICES*CTRL_WIDTH-1:0]                  r,
  output logic                                          env_valid,
  output logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] env_voice,
  output logic [OUT_BITS-1:0]                           env_level,
  output logic [VOICES-1:0]                             active,
  output logic                                          busy,
  output logic                                          overrun
);
  localparam int AB   = ACCUMULATOR_BITS;
  localparam int VW   = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int CNTW = $clog2(VOICES + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(VOICES);

  logic [2:0]          r_state [VOICES];
  logic [AB-1:0]       r_acc   [VOICES];
  logic [VOICES-1:0]   r_gq;
  logic [VOICES-1:0]   r_snap;
  logic [VOICES-1:0]   r_active;
  logic                r_busy;
  logic [CNTW-1:0]     r_cnt;
  logic                r_valid;
  logic [VW-1:0]       r_voice;
  logic [OUT_BITS-1:0] r_level;
  logic                r_overrun;

  logic                w_proc;
  logic [VW-1:0]       w_idx;
  logic [CTRL_WIDTH-1:0] w_a, w_d, w_s, w_r;
  logic [2:0]          w_nstate;
  logic [AB-1:0]       w_nacc;
  logic                w_ngq;

  // The count runs one past the last voice so busy covers the final output cycle.
  assign w_proc = r_busy && (r_cnt != LAST_CNT);
  assign w_idx  = w_proc ? VW'(r_cnt) : {VW{1'b0}};
  assign w_a    = a[w_idx*CTRL_WIDTH +: CTRL_WIDTH];
  assign w_d    = d[w_idx*CTRL_WIDTH +: CTRL_WIDTH];
  assign w_s    = s[w_idx*CTRL_WIDTH +: CTRL_WIDTH];
  assign w_r    = r[w_idx*CTRL_WIDTH +: CTRL_WIDTH];

  adsr_voice_step #(
    .ACCUMULATOR_BITS(ACCUMULATOR_BITS),
    .CTRL_WIDTH      (CTRL_WIDTH),
    .SAMPLE_CLK_FREQ (SAMPLE_CLK_FREQ),
    .RETRIGGER       (RETRIGGER)
  ) u_step (
    .i_state (r_state[w_idx]),
    .i_acc   (r_acc[w_idx]),
    .i_gate_q(r_gq[w_idx]),
    .i_g     (r_snap[w_idx]),
    .i_a     (w_a),
    .i_d     (w_d),
    .i_s     (w_s),
    .i_r     (w_r),
    .o_state (w_nstate),
    .o_acc   (w_nacc),
    .o_gate_q(w_ngq)
  );

  // Sweep sequencing, per-voice write-back and the registered output stream
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VOICES; v++) begin
        r_state[v] <= ST_OFF;
        r_acc[v]   <= {AB{1'b0}};
      end
      r_gq      <= {VOICES{1'b0}};
      r_snap    <= {VOICES{1'b0}};
      r_active  <= {VOICES{1'b0}};
      r_busy    <= 1'b0;
      r_cnt     <= {CNTW{1'b0}};
      r_valid   <= 1'b0;
      r_voice   <= {VW{1'b0}};
      r_level   <= {OUT_BITS{1'b0}};
      r_overrun <= 1'b0;
    end else begin
      if (low_strobe && r_busy) begin
        r_overrun <= 1'b1;
      end
      if (low_strobe && !r_busy) begin
        r_busy <= 1'b1;
        r_cnt  <= {CNTW{1'b0}};
        r_snap <= gate;
      end else if (w_proc) begin
        r_cnt <= r_cnt + CNTW'(1);
      end else begin
        r_busy <= 1'b0;
      end
      r_valid <= w_proc;
      if (w_proc) begin
        r_state[w_idx]  <= w_nstate;
        r_acc[w_idx]    <= w_nacc;
        r_gq[w_idx]     <= w_ngq;
        r_active[w_idx] <= (w_nstate != ST_OFF);
        r_voice         <= w_idx;
        r_level         <= w_nacc[AB-1 -: OUT_BITS];
      end
    end
  end

  assign env_valid = r_valid;
  assign env_voice = r_voice;
  assign env_level = r_level;
  assign active    = r_active;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_adsr_poly.sv
// Bench for adsr_poly: two instances (legato / hard retrigger) driven in
// parallel, a behavioural scoreboard per instance, a phase table on voice 0,
// and hand-written sweep/overrun and reset-mid-sweep sequences.
module tb_adsr_poly;
  localparam int NV = 8;
  localparam longint FULL = 64'hFFFFFF;
  localparam int S_OFF = 0, S_ATK = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  logic clk = 1'b0;
  logic rst, low_strobe;
  logic [NV-1:0] gate;
  logic [NV*4-1:0] a, d, s, r;
  logic ev0, ev1, busy0, busy1, ovr0, ovr1;
  logic [2:0] evo0, evo1;
  logic [23:0] lvl0, lvl1;
  logic [NV-1:0] act0, act1;

  always #5 clk = ~clk;

  adsr_poly #(.VOICES(NV), .ACCUMULATOR_BITS(24), .CTRL_WIDTH(4), .OUT_BITS(24),
              .SAMPLE_CLK_FREQ(48000), .RETRIGGER(0)) dut0 (
    .clk(clk), .rst(rst), .low_strobe(low_strobe), .gate(gate), .a(a), .d(d), .s(s), .r(r),
    .env_valid(ev0), .env_voice(evo0), .env_level(lvl0), .active(act0), .busy(busy0),
    .overrun(ovr0));

  adsr_poly #(.VOICES(NV), .ACCUMULATOR_BITS(24), .CTRL_WIDTH(4), .OUT_BITS(24),
              .SAMPLE_CLK_FREQ(48000), .RETRIGGER(1)) dut1 (
    .clk(clk), .rst(rst), .low_strobe(low_strobe), .gate(gate), .a(a), .d(d), .s(s), .r(r),
    .env_valid(ev1), .env_voice(evo1), .env_level(lvl1), .active(act1), .busy(busy1),
    .overrun(ovr1));

  int n_checks = 0;
  int n_bad = 0;

  typedef struct { int voice; longint level; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  longint last0, last1;

  int     m_st  [2][NV];
  longint m_acc [2][NV];
  bit     m_gq  [2][NV];

  real atk_t [16] = '{0.002, 0.008, 0.016, 0.024, 0.038, 0.056, 0.068, 0.080,
                      0.1, 0.25, 0.5, 0.8, 1.0, 3.0, 5.0, 8.0};

  typedef struct { bit g0; int s0; int n; longint e0; longint e1; bit act; } phase_t;
  phase_t ph [11];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint step_of(input real t);
    return longint'($floor(16777216.0 / (t * 48000.0)));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < NV; v++) begin
        m_st[m][v] = S_OFF; m_acc[m][v] = 0; m_gq[m][v] = 1'b0;
      end
  endtask

  // Advance the reference model by one strobe and queue every expected output.
  task automatic model_sweep();
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < NV; v++) begin
        int st; longint acc; longint sus; bit g;
        g = gate[v]; st = m_st[m][v]; acc = m_acc[m][v];
        sus = longint'(s[v*4 +: 4]) * 64'h111111;
        if (g && (!m_gq[m][v] || st == S_OFF)) begin
          st = S_ATK;
          if (m == 1) acc = 0;
        end else if (!g && (st == S_ATK || st == S_DEC || st == S_SUS)) st = S_REL;
        case (st)
          S_ATK: begin acc += step_of(atk_t[a[v*4 +: 4]]);
                   if (acc >= FULL) begin acc = FULL; st = S_DEC; end end
          S_DEC: begin acc -= step_of(3.0 * atk_t[d[v*4 +: 4]]);
                   if (acc <= sus) begin acc = sus; st = S_SUS; end end
          S_SUS: acc = sus;
          S_REL: begin acc -= step_of(3.0 * atk_t[r[v*4 +: 4]]);
                   if (acc <= 0) begin acc = 0; st = S_OFF; end end
          default: acc = 0;
        endcase
        m_st[m][v] = st; m_acc[m][v] = acc; m_gq[m][v] = g;
        if (m == 0) q0.push_back('{v, acc}); else q1.push_back('{v, acc});
      end
  endtask

  task automatic check_active();
    for (int v = 0; v < NV; v++) begin
      chk("active_dut0", longint'(act0[v]), longint'(m_st[0][v] != S_OFF));
      chk("active_dut1", longint'(act1[v]), longint'(m_st[1][v] != S_OFF));
    end
  endtask

  task automatic do_strobe();
    model_sweep();
    @(negedge clk); low_strobe = 1'b1;
    @(negedge clk); low_strobe = 1'b0;
    repeat (11) @(negedge clk);
    check_active();
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (ev0) begin
      if (q0.size() == 0) chk("sb0_unexpected_voice", longint'(evo0), -1);
      else begin
        exp_t e; e = q0.pop_front();
        chk("sb0_voice", longint'(evo0), e.voice);
        chk("sb0_level", longint'(lvl0), e.level);
      end
      if (evo0 == 3'd0) last0 = longint'(lvl0);
    end
  end

  always @(negedge clk) begin
    if (ev1) begin
      if (q1.size() == 0) chk("sb1_unexpected_voice", longint'(evo1), -1);
      else begin
        exp_t e; e = q1.pop_front();
        chk("sb1_voice", longint'(evo1), e.voice);
        chk("sb1_level", longint'(lvl1), e.level);
      end
      if (evo1 == 3'd0) last1 = longint'(lvl1);
    end
  end

  initial begin
    // voice 0: a=d=r=0 (2 ms / 6 ms), level after the phase for legato and hard retrigger
    ph[0]  = '{1'b1, 8,  96,  16777152, 16777152, 1'b1};
    ph[1]  = '{1'b1, 8,  1,   16777215, 16777215, 1'b1};
    ph[2]  = '{1'b1, 8,  134, 8971179,  8971179,  1'b1};
    ph[3]  = '{1'b1, 8,  1,   8947848,  8947848,  1'b1};
    ph[4]  = '{1'b1, 4,  1,   4473924,  4473924,  1'b1};
    ph[5]  = '{1'b1, 15, 1,   16777215, 16777215, 1'b1};
    ph[6]  = '{1'b0, 15, 144, 8388639,  8388639,  1'b1};
    ph[7]  = '{1'b1, 15, 1,   8563401,  174762,   1'b1};
    ph[8]  = '{1'b1, 15, 102, 16777215, 16777215, 1'b1};
    ph[9]  = '{1'b0, 15, 288, 63,       63,       1'b1};
    ph[10] = '{1'b0, 15, 1,   0,        0,        1'b0};

    rst = 1'b1; low_strobe = 1'b0; gate = '0; a = '0; d = '0; s = '0; r = '0;
    last0 = -1; last1 = -1;
    model_reset();
    for (int v = 1; v < NV; v++) begin
      a[v*4 +: 4] = 4'(v); d[v*4 +: 4] = 4'(v + 3); s[v*4 +: 4] = 4'(2 * v);
      r[v*4 +: 4] = 4'(9 - v);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_valid", longint'(ev0), 0);
    chk("rst_active", longint'(act0), 0);
    chk("rst_overrun", longint'(ovr0), 0);
    chk("rst_level", longint'(lvl0), 0);
    chk("rst_voice", longint'(evo1), 0);

    for (int p = 0; p < 11; p++) begin
      gate[0] = ph[p].g0;
      gate[NV-1:1] = 7'(p * 37 + 5);
      s[3:0] = 4'(ph[p].s0);
      for (int k = 0; k < ph[p].n; k++) do_strobe();
      chk($sformatf("phase%0d_lvl_legato", p), last0, ph[p].e0);
      chk($sformatf("phase%0d_lvl_hard", p), last1, ph[p].e1);
      chk($sformatf("phase%0d_active0", p), longint'(act0[0]), longint'(ph[p].act));
      chk($sformatf("phase%0d_active0_hard", p), longint'(act1[0]), longint'(ph[p].act));
    end

    // Sweep timing with a second strobe three cycles in: ignored, overrun sticks.
    gate = 8'b1100_1011;
    model_sweep();
    @(negedge clk); low_strobe = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("sweep_valid", longint'(ev0), longint'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk("sweep_voice", longint'(evo0), c - 2);
      chk("sweep_busy", longint'(busy0), longint'(c <= 9));
      chk("sweep_overrun", longint'(ovr0), longint'(c >= 4));
      low_strobe = (c == 3);
    end
    chk("overrun_hard", longint'(ovr1), 1);
    check_active();

    // Reset in cycle T+4 of a sweep, with a coincident strobe that must be ignored.
    gate = 8'b0011_0110;
    model_sweep();
    @(negedge clk); low_strobe = 1'b1;
    @(negedge clk); low_strobe = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); rst = 1'b1; low_strobe = 1'b1;
    @(negedge clk); rst = 1'b0; low_strobe = 1'b0;
    chk("midrst_busy", longint'(busy0), 0);
    chk("midrst_valid", longint'(ev0), 0);
    chk("midrst_active", longint'(act0), 0);
    chk("midrst_active_hard", longint'(act1), 0);
    chk("midrst_overrun", longint'(ovr0), 0);
    chk("midrst_voice", longint'(evo0), 0);
    chk("midrst_level", longint'(lvl0), 0);
    q0.delete(); q1.delete();
    model_reset();
    repeat (3) @(negedge clk);
    chk("midrst_strobe_ignored", longint'(busy0), 0);

    model_sweep();
    @(negedge clk); low_strobe = 1'b1;
    @(negedge clk); low_strobe = 1'b0;
    @(negedge clk);
    chk("restart_valid", longint'(ev0), 1);
    chk("restart_voice0", longint'(evo0), 0);
    repeat (10) @(negedge clk);
    check_active();
    do_strobe();

    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
